sram_ctrl: RTL and testbench

- Parametrised synchronous controller between the CPU memory port and an external asynchronous SRAM with active-low EN/OE/WE and per-byte lane enables.
- Converts single-word req/ack transactions into a timed SETUP/ACCESS/HOLD sequence, with configurable wait states and bus-turnaround cycles.
- Splits the bidirectional data bus into in/out/output-enable; the top level builds the tristate pad.
- Replaces the fixed-width, fixed-timing SRAM access path used in simulation with a synthesizable, width/depth-generic block.

---
 rtl/sram_ctrl_pkg.sv | 21 ++
 rtl/sram_ctrl.sv | 161 ++++++++++++++++
 tb/tb_sram_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types and constants for sram_ctrl
// Purpose: FSM state encoding, counter widths and byte-enable width helper.
// Ports:   none (package).
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TURN,
    ST_SETUP,
    ST_ACCESS,
    ST_HOLD
  } state_t;

  localparam int WAIT_CW = 4;
  localparam int TURN_CW = 2;

  function automatic int be_width(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - synchronous CPU-port to asynchronous SRAM controller
// Purpose: turns single-word req/ack transactions into SETUP/ACCESS/HOLD SRAM
//          cycles, with WAIT extra access cycles and TURN idle cycles between
//          a read and a following write.
// Ports:   clk, rst_n                  - clock, asynchronous active-low reset
//          req, we, addr, wdata, be    - CPU request, latched on acceptance
//          ack, rdata                  - completion pulse, read data (held)
//          ram_en_n/oe_n/we_n/be_n     - registered active-low SRAM strobes
//          ram_addr, ram_dq_o/oe/i     - SRAM address and split data bus
// Option:  SRAM_CTRL_POSTED_WR_EN - writes ack on acceptance and finish in
//          the background; reads always ack in HOLD.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int AW   = 20,
  parameter int DW   = 32,
  parameter int WAIT = 1,
  parameter int TURN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DW-1:0]     wdata,
  input  logic [DW/8-1:0]   be,
  output logic              ack,
  output logic [DW-1:0]     rdata,
  output logic              ram_en_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic [DW/8-1:0]   ram_be_n,
  output logic [AW-1:0]     ram_addr,
  output logic [DW-1:0]     ram_dq_o,
  output logic              ram_dq_oe,
  input  logic [DW-1:0]     ram_dq_i
);

  localparam int BW = be_width(DW);
  localparam logic [WAIT_CW-1:0] WAIT_LAST = WAIT_CW'(WAIT);
  localparam logic [TURN_CW-1:0] TURN_LAST = TURN_CW'((TURN > 0) ? TURN - 1 : 0);

  state_t               r_state;
  logic                 r_we;
  logic [BW-1:0]        r_be;
  logic                 r_last_wr;
  logic [WAIT_CW-1:0]   r_wait_cnt;
  logic [TURN_CW-1:0]   r_turn_cnt;
  logic                 r_ack;
  logic [DW-1:0]        r_rdata;
  logic                 r_ram_en_n;
  logic                 r_ram_oe_n;
  logic                 r_ram_we_n;
  logic [BW-1:0]        r_ram_be_n;
  logic [AW-1:0]        r_ram_addr;
  logic [DW-1:0]        r_ram_dq_o;
  logic                 r_ram_dq_oe;

  state_t               w_state_nxt;
  logic                 w_accept;
  logic                 w_op_wr;
  logic [BW-1:0]        w_op_be;
  logic                 w_en_n;
  logic                 w_oe_n;
  logic                 w_we_n;
  logic [BW-1:0]        w_be_n;
  logic                 w_dq_oe;
  logic                 w_ack;

  assign w_accept = (r_state == ST_IDLE) && req;
  // The pins are registered from the next state, so the operation seen by the
  // output decode must come straight from the inputs on the accepting edge.
  assign w_op_wr  = w_accept ? we : r_we;
  assign w_op_be  = w_accept ? be : r_be;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (req) w_state_nxt = (we && !r_last_wr && (TURN > 0)) ? ST_TURN : ST_SETUP;
      ST_TURN:   if (r_turn_cnt == TURN_LAST) w_state_nxt = ST_SETUP;
      ST_SETUP:  w_state_nxt = ST_ACCESS;
      ST_ACCESS: if (r_wait_cnt == WAIT_LAST) w_state_nxt = ST_HOLD;
      ST_HOLD:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase

    w_en_n  = 1'b1;
    w_oe_n  = 1'b1;
    w_we_n  = 1'b1;
    w_be_n  = '1;
    w_dq_oe = 1'b0;
    if (w_state_nxt == ST_SETUP || w_state_nxt == ST_ACCESS || w_state_nxt == ST_HOLD) begin
      w_en_n  = 1'b0;
      w_be_n  = w_op_wr ? ~w_op_be : '0;
      w_dq_oe = w_op_wr;
    end
    if (w_state_nxt == ST_ACCESS) begin
      w_oe_n = w_op_wr;
      w_we_n = !w_op_wr;
    end

`ifdef SRAM_CTRL_POSTED_WR_EN
    // A posted write acks the cycle after acceptance even if a turnaround
    // precedes its SETUP; the FSM stays busy until its HOLD is done.
    w_ack = (w_accept && we) || (w_state_nxt == ST_HOLD && !w_op_wr);
`else
    w_ack = (w_state_nxt == ST_HOLD);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_be        <= '0;
      r_last_wr   <= 1'b1;
      r_wait_cnt  <= '0;
      r_turn_cnt  <= '0;
      r_ack       <= 1'b0;
      r_rdata     <= '0;
      r_ram_en_n  <= 1'b1;
      r_ram_oe_n  <= 1'b1;
      r_ram_we_n  <= 1'b1;
      r_ram_be_n  <= '1;
      r_ram_addr  <= '0;
      r_ram_dq_o  <= '0;
      r_ram_dq_oe <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ack       <= w_ack;
      r_ram_en_n  <= w_en_n;
      r_ram_oe_n  <= w_oe_n;
      r_ram_we_n  <= w_we_n;
      r_ram_be_n  <= w_be_n;
      r_ram_dq_oe <= w_dq_oe;
      r_wait_cnt  <= (r_state == ST_ACCESS) ? r_wait_cnt + 1'b1 : '0;
      r_turn_cnt  <= (r_state == ST_TURN) ? r_turn_cnt + 1'b1 : '0;
      if (w_accept) begin
        r_we       <= we;
        r_be       <= be;
        r_last_wr  <= we;
        r_ram_addr <= addr;
        r_ram_dq_o <= wdata;
      end
      if (r_state == ST_ACCESS && r_wait_cnt == WAIT_LAST && !r_we) begin
        r_rdata <= ram_dq_i;
      end
    end
  end

  assign ack       = r_ack;
  assign rdata     = r_rdata;
  assign ram_en_n  = r_ram_en_n;
  assign ram_oe_n  = r_ram_oe_n;
  assign ram_we_n  = r_ram_we_n;
  assign ram_be_n  = r_ram_be_n;
  assign ram_addr  = r_ram_addr;
  assign ram_dq_o  = r_ram_dq_o;
  assign ram_dq_oe = r_ram_dq_oe;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - self-checking bench for sram_ctrl
module tb_sram_ctrl;

  localparam int WAIT_P = 1;
  localparam int TURN_P = 1;
`ifdef SRAM_CTRL_POSTED_WR_EN
  localparam bit POSTED = 1'b1;
  localparam int L_WR_T   = 1;
  localparam int L_RW_B2B = 2;
  localparam int L_WR_B2B = 9;
`else
  localparam bit POSTED = 1'b0;
  localparam int L_WR_T   = 5;
  localparam int L_RW_B2B = 6;
  localparam int L_WR_B2B = 5;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [19:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;
  logic        ack;
  logic [31:0] rdata;
  logic        ram_en_n, ram_oe_n, ram_we_n, ram_dq_oe;
  logic [3:0]  ram_be_n;
  logic [19:0] ram_addr;
  logic [31:0] ram_dq_o;
  logic [31:0] ram_dq_i;

  always #5 clk = ~clk;

  sram_ctrl #(.AW(20), .DW(32), .WAIT(WAIT_P), .TURN(TURN_P)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .be(be), .ack(ack), .rdata(rdata), .ram_en_n(ram_en_n), .ram_oe_n(ram_oe_n),
    .ram_we_n(ram_we_n), .ram_be_n(ram_be_n), .ram_addr(ram_addr),
    .ram_dq_o(ram_dq_o), .ram_dq_oe(ram_dq_oe), .ram_dq_i(ram_dq_i)
  );

  typedef struct {
    int          start;
    int          t;
    bit          w;
    logic [19:0] a;
    logic [31:0] d;
    logic [3:0]  b;
  } txn_t;

  txn_t        tx[$];
  logic [31:0] exp_mem [0:255];
  logic [31:0] sram [0:255];
  bit          sram_loaded = 1'b0;
  bit          last_wr = 1'b1;
  int          busy_until = 0;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          oe_total = 0;
  int          we_total = 0;
  logic [3:0]  be_seen = 4'hF;
  int          last_lat = 0;
  int          last_pre = 0;
  logic [31:0] last_rd = '0;

  function automatic logic [31:0] init_word(input int i);
    if (i == 16) return 32'hDEADBEEF;
    if (i == 32) return 32'hAABBCCDD;
    return {4{i[7:0]}};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Asynchronous SRAM: drives data while selected and output-enabled,
  // stores enabled byte lanes while write-enabled.
  assign ram_dq_i = (!ram_en_n && !ram_oe_n && !ram_dq_oe) ? sram[ram_addr[7:0]] : 32'hBAD0F00D;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!sram_loaded) begin
      for (int i = 0; i < 256; i++) sram[i] <= init_word(i);
      sram_loaded <= 1'b1;
    end else if (!ram_en_n && !ram_we_n && ram_dq_oe) begin
      for (int b = 0; b < 4; b++)
        if (!ram_be_n[b]) sram[ram_addr[7:0]][8*b +: 8] <= ram_dq_o[8*b +: 8];
    end
  end

  // Per-cycle compare: each accepted transaction occupies cycles
  // start .. start+t+WAIT+2 (TURN x t, SETUP, ACCESS x WAIT+1, HOLD).
  always @(negedge clk) begin
    logic       e_en, e_oe, e_we, e_dqoe, e_ack;
    logic [3:0] e_be;
    int         idx, k;
    if (rst_n) begin
      idx = -1;
      k = 0;
      foreach (tx[i])
        if (cyc >= tx[i].start && cyc <= tx[i].start + tx[i].t + WAIT_P + 2) begin
          idx = i;
          k = cyc - tx[i].start;
        end
      e_en = 1'b1; e_oe = 1'b1; e_we = 1'b1; e_be = 4'hF; e_dqoe = 1'b0; e_ack = 1'b0;
      if (idx >= 0) begin
        if (POSTED && tx[idx].w && k == 0) e_ack = 1'b1;
        if (k >= tx[idx].t) begin
          e_en   = 1'b0;
          e_be   = tx[idx].w ? ~tx[idx].b : 4'h0;
          e_dqoe = tx[idx].w;
          if (k > tx[idx].t && k <= tx[idx].t + WAIT_P + 1) begin
            e_oe = tx[idx].w;
            e_we = !tx[idx].w;
          end
          if (k == tx[idx].t + WAIT_P + 2 && !(POSTED && tx[idx].w)) e_ack = 1'b1;
          chk("ram_addr", ram_addr, tx[idx].a);
          if (tx[idx].w) chk("ram_dq_o", ram_dq_o, tx[idx].d);
        end
      end
      chk("ram_en_n", ram_en_n, e_en);
      chk("ram_oe_n", ram_oe_n, e_oe);
      chk("ram_we_n", ram_we_n, e_we);
      chk("ram_be_n", ram_be_n, e_be);
      chk("ram_dq_oe", ram_dq_oe, e_dqoe);
      chk("ack", ack, e_ack);
      chk("bus_contention", !ram_oe_n && ram_dq_oe, 1'b0);
      if (!ram_oe_n) oe_total++;
      if (!ram_we_n) begin
        we_total++;
        be_seen = ram_be_n;
      end
    end
  end

  task automatic issue(input bit w, input logic [19:0] a, input logic [31:0] d,
                       input logic [3:0] b, output int c, output int st, output int t);
    txn_t x;
    c = cyc;
    x.start = (c + 1 > busy_until) ? c + 1 : busy_until;
    x.t = (w && !last_wr && TURN_P > 0) ? TURN_P : 0;
    x.w = w; x.a = a; x.d = d; x.b = b;
    tx.push_back(x);
    busy_until = x.start + x.t + WAIT_P + 4;
    last_wr = w;
    if (w)
      for (int i = 0; i < 4; i++)
        if (b[i]) exp_mem[a[7:0]][8*i +: 8] = d[8*i +: 8];
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    st = x.start;
    t = x.t;
  endtask

  task automatic do_txn(input bit w, input logic [19:0] a, input logic [31:0] d,
                        input logic [3:0] b, input int gap);
    int c, st, t, ack_k;
    bit seen_en, got;
    repeat (gap) @(negedge clk);
    issue(w, a, d, b, c, st, t);
    ack_k = (POSTED && w) ? 0 : t + WAIT_P + 2;
    seen_en = 1'b0;
    got = 1'b0;
    last_pre = 0;
    for (int n = 0; n < 64 && !got; n++) begin
      @(negedge clk);
      if (!seen_en && ram_en_n) last_pre++;
      else seen_en = 1'b1;
      if (ack) got = 1'b1;
    end
    if (!got) chk("ack_timeout", got, 1'b1);
    last_lat = cyc - c;
    last_rd = rdata;
    chk("ack_latency_model", last_lat, st + ack_k - c);
    if (!w) chk("rdata_model", rdata, exp_mem[a[7:0]]);
    req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c, st, t, oe0, we0, ack_cnt;
    bit hit;
    for (int i = 0; i < 256; i++) exp_mem[i] = init_word(i);

    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_en_n", ram_en_n, 1'b1);
    chk("rst_oe_n", ram_oe_n, 1'b1);
    chk("rst_we_n", ram_we_n, 1'b1);
    chk("rst_be_n", ram_be_n, 4'hF);
    chk("rst_addr", ram_addr, 20'h0);
    chk("rst_dq_o", ram_dq_o, 32'h0);
    chk("rst_dq_oe", ram_dq_oe, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Plain read of preloaded word.
    oe0 = oe_total;
    do_txn(1'b0, 20'h00010, 32'h0, 4'h0, 2);
    chk("rd1_latency", last_lat, 4);
    chk("rd1_data", last_rd, 32'hDEADBEEF);
    chk("rd1_no_turn", last_pre, 0);
    repeat (4) @(negedge clk);
    chk("rd1_oe_cycles", oe_total - oe0, 2);

    // Partial write after a read: one turnaround cycle, lanes 0 and 2 only.
    we0 = we_total;
    do_txn(1'b1, 20'h00020, 32'h12345678, 4'b0101, 2);
    chk("wr_turn_cycles", last_pre, 1);
    chk("wr_latency", last_lat, L_WR_T);
    repeat (6) @(negedge clk);
    chk("wr_be_n", be_seen, 4'b1010);
    chk("wr_we_cycles", we_total - we0, 2);
    chk("rdata_held", rdata, 32'hDEADBEEF);
    do_txn(1'b0, 20'h00020, 32'h0, 4'h0, 2);
    chk("rd_partial", last_rd, 32'hAA34CC78);
    chk("rd_after_wr_latency", last_lat, 4);

    // Read immediately followed by a write.
    do_txn(1'b0, 20'h00010, 32'h0, 4'h0, 2);
    do_txn(1'b1, 20'h00040, 32'hCAFEF00D, 4'hF, 0);
    chk("rw_b2b_latency", last_lat, L_RW_B2B);
    repeat (6) @(negedge clk);
    do_txn(1'b0, 20'h00040, 32'h0, 4'h0, 2);
    chk("rd_cafe", last_rd, 32'hCAFEF00D);

    // Write with no lanes enabled still runs and acks; memory unchanged.
    do_txn(1'b1, 20'h00041, 32'h11111111, 4'h1, 2);
    we0 = we_total;
    do_txn(1'b1, 20'h00010, 32'h0, 4'h0, 2);
    repeat (6) @(negedge clk);
    chk("be0_we_cycles", we_total - we0, 2);
    chk("be0_be_n", be_seen, 4'hF);
    do_txn(1'b0, 20'h00010, 32'h0, 4'h0, 2);
    chk("be0_preserved", last_rd, 32'hDEADBEEF);

    // Reset during the ACCESS phase of a write.
    repeat (2) @(negedge clk);
    issue(1'b1, 20'h00030, 32'h55555555, 4'hF, c, st, t);
    hit = 1'b0;
    for (int n = 0; n < 20 && !hit; n++) begin
      @(negedge clk);
      if (cyc == st + t + 1) hit = 1'b1;
    end
    chk("abort_reached_access", hit, 1'b1);
    chk("abort_we_low", ram_we_n, 1'b0);
    #1;
    rst_n = 1'b0;
    tx.delete();
    last_wr = 1'b1;
    busy_until = 0;
    req = 1'b0;
    #1;
    chk("abort_en_n", ram_en_n, 1'b1);
    chk("abort_we_n", ram_we_n, 1'b1);
    chk("abort_dq_oe", ram_dq_oe, 1'b0);
    chk("abort_ack", ack, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    ack_cnt = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (ack) ack_cnt++;
    end
    chk("abort_no_ack", ack_cnt, 0);
    do_txn(1'b0, 20'h00010, 32'h0, 4'h0, 0);
    chk("post_abort_latency", last_lat, 4);
    chk("post_abort_data", last_rd, 32'hDEADBEEF);

    // Write then read back-to-back.
    do_txn(1'b1, 20'h00050, 32'h0BADCAFE, 4'hF, 2);
    do_txn(1'b0, 20'h00050, 32'h0, 4'h0, 0);
    chk("wr_rd_b2b_latency", last_lat, L_WR_B2B);
    chk("wr_rd_b2b_data", last_rd, 32'h0BADCAFE);
    repeat (6) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
